// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite encodings, slave FSM states and byte-lane decode
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_e;

    // Little-endian byte lanes touched by a transfer of the given size at the given offset.
    function automatic logic [3:0] byte_enables(input logic [1:0] addr_lo, input logic [2:0] size);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// rtl/ahb_sram_bank.sv - synchronous word RAM with byte-lane writes and registered read
module ahb_sram_bank #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write and read-old-data registered read; output holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave backed by a word SRAM, with wait states and ERROR responses
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                MEM_DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic              hmastlock,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int              IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_DEPTH) << 2;

    state_e            state, state_nx;
    logic [3:0]        count, count_nx;
    logic              accept, legal, aligned, in_range;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  acc_idx;
    logic              dp_valid, dp_write;
    logic [3:0]        dp_be;
    logic [IDX_W-1:0]  dp_idx;
    logic              wr_fire, rd_fire, rd_issue;
    logic [3:0]        fwd_be;
    logic [31:0]       fwd_data, ram_q, rd_merged, hrdata_q;
    logic              unused_inputs;

    assign unused_inputs = ^{hburst, hmastlock, htrans[0]};

    assign offset   = haddr - BASE_ADDR;
    assign acc_idx  = offset[IDX_W+1:2];
    assign in_range = (haddr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    assign legal    = aligned && in_range;
    // Only a beat we are ready to end can hand over the address phase.
    assign accept   = hsel && hready && htrans[1] && hreadyout;
    assign rd_issue = accept && legal && !hwrite;
    assign wr_fire  = hreadyout && dp_valid && dp_write;
    assign rd_fire  = hreadyout && dp_valid && !dp_write;

    // Alignment check; sizes above a word are never legal.
    always_comb begin
        aligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: aligned = 1'b1;
            HSIZE_HALF: aligned = ~haddr[0];
            HSIZE_WORD: aligned = (haddr[1:0] == 2'b00);
            default:    aligned = 1'b0;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= S_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // Response outputs depend on state only, so hresp moves only on transitions.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            S_WAIT:  hreadyout = (count == 4'd0);
            S_ERR1:  begin hreadyout = 1'b0; hresp = HRESP_ERROR; end
            S_ERR2:  hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Next state: drain current beat, then let an accepted transfer override.
    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            S_WAIT: begin
                if (count != 4'd0) count_nx = count - 4'd1;
                else               state_nx = S_IDLE;
            end
            S_ERR1:  state_nx = S_ERR2;
            S_ERR2:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (accept) begin
            if (!legal) begin
                state_nx = S_ERR1;
                count_nx = 4'd0;
            end else if (WAIT_STATES > 0) begin
                state_nx = S_WAIT;
                count_nx = 4'(WAIT_STATES);
            end else begin
                state_nx = S_IDLE;
                count_nx = 4'd0;
            end
        end
    end

    // Data-phase context, advanced whenever the current beat ends.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_be    <= 4'd0;
            dp_idx   <= '0;
        end else if (hreadyout) begin
            dp_valid <= accept && legal;
            dp_write <= hwrite;
            dp_be    <= byte_enables(haddr[1:0], hsize);
            dp_idx   <= acc_idx;
        end
    end

    // Remember bytes written to the word a read is fetching in the same cycle.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            fwd_be   <= 4'd0;
            fwd_data <= 32'd0;
        end else if (rd_issue) begin
            fwd_be   <= (wr_fire && dp_idx == acc_idx) ? dp_be : 4'd0;
            fwd_data <= hwdata;
        end
    end

    // Merge forwarded bytes over the RAM output.
    always_comb begin
        rd_merged = ram_q;
        for (int b = 0; b < 4; b++) begin
            if (fwd_be[b]) rd_merged[8*b +: 8] = fwd_data[8*b +: 8];
        end
    end

    // Hold the last completed read data on the bus.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)       hrdata_q <= 32'd0;
        else if (rd_fire) hrdata_q <= rd_merged;
    end

    assign hrdata = rd_fire ? rd_merged : hrdata_q;

    ahb_sram_bank #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (hclk),
        .rd_en   (rd_issue),
        .rd_idx  (acc_idx),
        .wr_en   (wr_fire),
        .wr_idx  (dp_idx),
        .wr_be   (dp_be),
        .wr_data (hwdata),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - randomized self-checking bench against a transfer-level model
module tb_ahb_lite_sram_slave;

    localparam logic [31:0] BASE3 = 32'h0000_4000;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel3, hwrite, hmastlock;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        ro0, ro3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rdata0, rdata3;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
        .hready(ro0), .hwdata(hwdata), .hreadyout(ro0), .hresp(resp0), .hrdata(rdata0)
    );

    ahb_lite_sram_slave #(.BASE_ADDR(BASE3), .WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
        .hready(ro3), .hwdata(hwdata), .hreadyout(ro3), .hresp(resp3), .hrdata(rdata3)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_ops;
    logic        op_wr    [64];
    logic [31:0] op_addr  [64];
    logic [31:0] op_wdata [64];
    logic [2:0]  op_size  [64];
    int          ob_stall [64];
    logic [1:0]  ob_resp_first [64];
    logic [1:0]  ob_resp_last  [64];
    logic [31:0] ob_rdata [64];
    int          ob_edges;
    bit          ob_timeout;
    int          ex_stall [64];
    logic [1:0]  ex_resp  [64];
    logic [31:0] ex_rdata [64];
    logic [31:0] mdl [int];
    logic [31:0] last_rd [2];

    task automatic add_op(input logic wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        op_wr[n_ops] = wr; op_addr[n_ops] = a; op_size[n_ops] = s; op_wdata[n_ops] = d;
        n_ops++;
    endtask

    function automatic logic [31:0] base_of(input int which);
        return (which == 3) ? BASE3 : 32'd0;
    endfunction

    function automatic bit is_legal(input int which, input logic [31:0] a, input logic [2:0] s);
        logic [31:0] base;
        base = base_of(which);
        if (s > 3'd2) return 1'b0;
        if ((a % (32'd1 << s)) != 32'd0) return 1'b0;
        return (a >= base) && (a < base + 32'd4096);
    endfunction

    // Transfer-level model: each op completes in order; reads see every earlier write.
    task automatic model_run(input int which);
        int          d, key, lane;
        logic [31:0] w, base;
        bit          legal;
        d = (which == 3) ? 1 : 0;
        base = base_of(which);
        for (int k = 0; k < n_ops; k++) begin
            legal = is_legal(which, op_addr[k], op_size[k]);
            ex_stall[k] = legal ? ((which == 3) ? 3 : 0) : 1;
            ex_resp[k]  = legal ? 2'b00 : 2'b01;
            if (legal) begin
                key = d * 100000 + int'((op_addr[k] - base) >> 2);
                w = mdl.exists(key) ? mdl[key] : 32'd0;
                if (op_wr[k]) begin
                    for (int b = 0; b < (1 << op_size[k]); b++) begin
                        lane = int'(op_addr[k][1:0]) + b;
                        w[8*lane +: 8] = op_wdata[k][8*lane +: 8];
                    end
                    mdl[key] = w;
                end else begin
                    last_rd[d] = w;
                end
            end
            ex_rdata[k] = last_rd[d];
        end
    endtask

    task automatic drive_addr(input int which, input int i);
        if (i < n_ops) begin
            hsel0 = (which == 0); hsel3 = (which == 3);
            htrans = 2'(32'd2 + $urandom_range(0, 1));
            haddr = op_addr[i]; hwrite = op_wr[i]; hsize = op_size[i];
        end else begin
            hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0; haddr = $urandom; hwrite = 1'b0; hsize = 3'd2;
        end
        hburst = 3'($urandom_range(0, 7));
        hmastlock = 1'($urandom_range(0, 1));
    endtask

    // Pipelined bus driver: records per-op stall count, responses and read data.
    task automatic run_ops(input int which);
        int          i, dp, cyc;
        bit          first;
        logic        rdy;
        logic [1:0]  rs;
        logic [31:0] rd;
        i = 0; dp = -1; cyc = 0; first = 0; ob_edges = 0; ob_timeout = 0;
        drive_addr(which, i);
        while (1) begin
            @(negedge hclk);
            rdy = (which == 3) ? ro3 : ro0;
            rs  = (which == 3) ? resp3 : resp0;
            rd  = (which == 3) ? rdata3 : rdata0;
            if (dp >= 0) begin
                if (first) begin ob_resp_first[dp] = rs; first = 0; end
                if (!rdy) ob_stall[dp]++;
                else begin ob_resp_last[dp] = rs; ob_rdata[dp] = rd; end
            end
            if (dp < 0 && i >= n_ops) break;
            if (cyc >= 400) begin ob_timeout = 1; break; end
            @(posedge hclk); #1;
            cyc++; ob_edges++;
            if (rdy) begin
                if (i < n_ops) begin
                    dp = i; ob_stall[dp] = 0; first = 1; hwdata = op_wdata[dp]; i++;
                end else begin
                    dp = -1;
                end
                drive_addr(which, i);
            end
        end
        drive_addr(which, n_ops);
    endtask

    task automatic test_reset();
        hreset = 1'b1; n_ops = 0; drive_addr(0, 0); hwdata = 32'd0;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        @(negedge hclk);
        n_checks++; if (ro0 !== 1'b1) begin n_fail++; $display("FAIL reset hreadyout0: got %b want 1", ro0); end
        n_checks++; if (resp0 !== 2'b00) begin n_fail++; $display("FAIL reset hresp0: got %b want 00", resp0); end
        n_checks++; if (rdata0 !== 32'd0) begin n_fail++; $display("FAIL reset hrdata0: got %h want 0", rdata0); end
        n_checks++; if (ro3 !== 1'b1) begin n_fail++; $display("FAIL reset hreadyout3: got %b want 1", ro3); end
        n_checks++; if (rdata3 !== 32'd0) begin n_fail++; $display("FAIL reset hrdata3: got %h want 0", rdata3); end
        hsel3 = 1'b1; htrans = 2'd1; haddr = BASE3; hwrite = 1'b0;
        @(posedge hclk); #1;
        htrans = 2'd0;
        @(posedge hclk); #1;
        hsel3 = 1'b0;
        n_checks++; if (ro3 !== 1'b1) begin n_fail++; $display("FAIL busy_idle hreadyout3: got %b want 1", ro3); end
        n_checks++; if (resp3 !== 2'b00) begin n_fail++; $display("FAIL busy_idle hresp3: got %b want 00", resp3); end
    endtask

    task automatic check_ops(input string name);
        // kept per scenario via loop below
    endtask

    task automatic test_forward();
        n_ops = 0;
        add_op(1, 32'h10, 3'd2, 32'hDEADBEEF);
        add_op(0, 32'h10, 3'd2, $urandom);
        model_run(0); run_ops(0);
        n_checks++; if (ob_timeout !== 1'b0) begin n_fail++; $display("FAIL forward timeout: got %b want 0", ob_timeout); end
        for (int k = 0; k < n_ops; k++) begin
            n_checks++; if (ob_stall[k] !== ex_stall[k]) begin n_fail++; $display("FAIL forward stall op%0d: got %0d want %0d", k, ob_stall[k], ex_stall[k]); end
            n_checks++; if (ob_resp_last[k] !== ex_resp[k]) begin n_fail++; $display("FAIL forward hresp op%0d: got %b want %b", k, ob_resp_last[k], ex_resp[k]); end
            n_checks++; if (ob_rdata[k] !== ex_rdata[k]) begin n_fail++; $display("FAIL forward hrdata op%0d: got %h want %h", k, ob_rdata[k], ex_rdata[k]); end
        end
        n_checks++; if (ob_rdata[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL forward value: got %h want deadbeef", ob_rdata[1]); end
    endtask

    task automatic test_byte_write();
        n_ops = 0;
        add_op(1, 32'h20, 3'd2, 32'h11223344);
        add_op(1, 32'h23, 3'd0, 32'hAA000000);
        add_op(0, 32'h20, 3'd2, $urandom);
        model_run(0); run_ops(0);
        n_checks++; if (ob_timeout !== 1'b0) begin n_fail++; $display("FAIL byte timeout: got %b want 0", ob_timeout); end
        for (int k = 0; k < n_ops; k++) begin
            n_checks++; if (ob_stall[k] !== ex_stall[k]) begin n_fail++; $display("FAIL byte stall op%0d: got %0d want %0d", k, ob_stall[k], ex_stall[k]); end
            n_checks++; if (ob_rdata[k] !== ex_rdata[k]) begin n_fail++; $display("FAIL byte hrdata op%0d: got %h want %h", k, ob_rdata[k], ex_rdata[k]); end
        end
        n_checks++; if (ob_rdata[2] !== 32'hAA223344) begin n_fail++; $display("FAIL byte value: got %h want aa223344", ob_rdata[2]); end
    endtask

    task automatic test_wait_states();
        n_ops = 0;
        add_op(1, BASE3 + 32'h8, 3'd2, 32'hCAFEF00D);
        add_op(0, BASE3 + 32'h8, 3'd2, $urandom);
        add_op(1, BASE3 + 32'hFFE, 3'd1, 32'h5A5A1234);
        add_op(0, BASE3 + 32'hFFC, 3'd2, $urandom);
        model_run(3); run_ops(3);
        n_checks++; if (ob_timeout !== 1'b0) begin n_fail++; $display("FAIL wait timeout: got %b want 0", ob_timeout); end
        for (int k = 0; k < n_ops; k++) begin
            n_checks++; if (ob_stall[k] !== ex_stall[k]) begin n_fail++; $display("FAIL wait stall op%0d: got %0d want %0d", k, ob_stall[k], ex_stall[k]); end
            n_checks++; if (ob_resp_first[k] !== ex_resp[k]) begin n_fail++; $display("FAIL wait hresp op%0d: got %b want %b", k, ob_resp_first[k], ex_resp[k]); end
            n_checks++; if (ob_rdata[k] !== ex_rdata[k]) begin n_fail++; $display("FAIL wait hrdata op%0d: got %h want %h", k, ob_rdata[k], ex_rdata[k]); end
        end
    endtask

    task automatic test_error();
        n_ops = 0;
        add_op(1, 32'h00, 3'd2, 32'h55667788);
        add_op(1, 32'h01, 3'd1, 32'hFFFFFFFF);
        add_op(1, 32'h1000, 3'd2, 32'h0BADF00D);
        add_op(1, 32'h04, 3'd3, 32'h12345678);
        add_op(0, 32'h02, 3'd2, $urandom);
        add_op(0, 32'h00, 3'd2, $urandom);
        model_run(0); run_ops(0);
        n_checks++; if (ob_timeout !== 1'b0) begin n_fail++; $display("FAIL error timeout: got %b want 0", ob_timeout); end
        for (int k = 0; k < n_ops; k++) begin
            n_checks++; if (ob_stall[k] !== ex_stall[k]) begin n_fail++; $display("FAIL error stall op%0d: got %0d want %0d", k, ob_stall[k], ex_stall[k]); end
            n_checks++; if (ob_resp_first[k] !== ex_resp[k]) begin n_fail++; $display("FAIL error hresp1 op%0d: got %b want %b", k, ob_resp_first[k], ex_resp[k]); end
            n_checks++; if (ob_resp_last[k] !== ex_resp[k]) begin n_fail++; $display("FAIL error hresp2 op%0d: got %b want %b", k, ob_resp_last[k], ex_resp[k]); end
            n_checks++; if (ob_rdata[k] !== ex_rdata[k]) begin n_fail++; $display("FAIL error hrdata op%0d: got %h want %h", k, ob_rdata[k], ex_rdata[k]); end
        end
    endtask

    task automatic test_back_to_back();
        n_ops = 0;
        for (int k = 0; k < 8; k++) add_op(1, 32'h200 + 32'(4 * k), 3'd2, $urandom);
        for (int k = 0; k < 8; k++) add_op(0, 32'h200 + 32'(4 * k), 3'd2, $urandom);
        model_run(0); run_ops(0);
        n_checks++; if (ob_edges !== n_ops + 1) begin n_fail++; $display("FAIL b2b edges: got %0d want %0d", ob_edges, n_ops + 1); end
        for (int k = 0; k < n_ops; k++) begin
            n_checks++; if (ob_stall[k] !== ex_stall[k]) begin n_fail++; $display("FAIL b2b stall op%0d: got %0d want %0d", k, ob_stall[k], ex_stall[k]); end
            n_checks++; if (ob_rdata[k] !== ex_rdata[k]) begin n_fail++; $display("FAIL b2b hrdata op%0d: got %h want %h", k, ob_rdata[k], ex_rdata[k]); end
        end
    endtask

    task automatic test_reset_in_wait();
        @(posedge hclk); #1;
        hsel3 = 1'b1; htrans = 2'd2; haddr = BASE3 + 32'h8; hwrite = 1'b0; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel3 = 1'b0; htrans = 2'd0;
        @(negedge hclk);
        n_checks++; if (ro3 !== 1'b0) begin n_fail++; $display("FAIL rstwait stalled: got %b want 0", ro3); end
        #2 hreset = 1'b1;
        #1;
        n_checks++; if (ro3 !== 1'b1) begin n_fail++; $display("FAIL rstwait hreadyout: got %b want 1", ro3); end
        n_checks++; if (resp3 !== 2'b00) begin n_fail++; $display("FAIL rstwait hresp: got %b want 00", resp3); end
        n_checks++; if (rdata3 !== 32'd0) begin n_fail++; $display("FAIL rstwait hrdata: got %h want 0", rdata3); end
        @(posedge hclk); #1 hreset = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        n_ops = 0;
        add_op(0, BASE3 + 32'h8, 3'd2, $urandom);
        add_op(0, BASE3 + 32'hFFC, 3'd2, $urandom);
        model_run(3); run_ops(3);
        n_checks++; if (ob_timeout !== 1'b0) begin n_fail++; $display("FAIL rstwait timeout: got %b want 0", ob_timeout); end
        for (int k = 0; k < n_ops; k++) begin
            n_checks++; if (ob_stall[k] !== ex_stall[k]) begin n_fail++; $display("FAIL rstwait stall op%0d: got %0d want %0d", k, ob_stall[k], ex_stall[k]); end
            n_checks++; if (ob_rdata[k] !== ex_rdata[k]) begin n_fail++; $display("FAIL rstwait hrdata op%0d: got %h want %h", k, ob_rdata[k], ex_rdata[k]); end
        end
    endtask

    task automatic test_random(input int which, input int count);
        logic [31:0] base, a;
        logic [2:0]  s;
        base = base_of(which);
        n_ops = 0;
        for (int k = 0; k < 16; k++) add_op(1, base + 32'h100 + 32'(4 * k), 3'd2, $urandom);
        for (int k = 0; k < count; k++) begin
            a = base + 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = base + 32'h1000 + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = base - 32'd4;
            s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            add_op(1'($urandom_range(0, 1)), a, s, $urandom);
        end
        model_run(which); run_ops(which);
        n_checks++; if (ob_timeout !== 1'b0) begin n_fail++; $display("FAIL random%0d timeout: got %b want 0", which, ob_timeout); end
        for (int k = 0; k < n_ops; k++) begin
            n_checks++; if (ob_stall[k] !== ex_stall[k]) begin n_fail++; $display("FAIL random%0d stall op%0d addr %h: got %0d want %0d", which, k, op_addr[k], ob_stall[k], ex_stall[k]); end
            n_checks++; if (ob_resp_first[k] !== ex_resp[k]) begin n_fail++; $display("FAIL random%0d hresp1 op%0d: got %b want %b", which, k, ob_resp_first[k], ex_resp[k]); end
            n_checks++; if (ob_resp_last[k] !== ex_resp[k]) begin n_fail++; $display("FAIL random%0d hresp2 op%0d: got %b want %b", which, k, ob_resp_last[k], ex_resp[k]); end
            n_checks++; if (ob_rdata[k] !== ex_rdata[k]) begin n_fail++; $display("FAIL random%0d hrdata op%0d addr %h: got %h want %h", which, k, op_addr[k], ob_rdata[k], ex_rdata[k]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_byte_write();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_reset_in_wait();
        test_random(0, 40);
        test_random(3, 24);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
